// File: rtl/imem_access_arbiter.sv
// Arbitrates the byte-organised instruction memory between fetch (32-bit reads)
// and a program loader (4-cycle byte-write bursts), with starvation protection.
`timescale 1ns/1ps
module imem_access_arbiter #(
  parameter int unsigned MEM_BYTES    = 16384,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  output logic        fetch_gnt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic        fetch_fault,
  input  logic        load_req,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        load_ack,
  output logic        load_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wbyte,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned    CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0]    LAST_WORD = 32'(MEM_BYTES - 4);
  localparam logic [CW-1:0]  SLIM      = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, WB0, WB1, WB2, WB3} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_starve, w_starve_nxt;
  logic [31:0]   r_lat_addr, r_lat_data, r_fetch_instr;
  logic          r_fetch_valid, r_fetch_fault, r_load_err;
  logic          w_load_wins, w_load_ok, w_fetch_bad, w_gnt, w_idle;
  logic [1:0]    w_idx;

  assign w_idle      = (r_state == IDLE);
  assign w_load_wins = load_req && (!fetch_req || r_starve == SLIM);
  assign w_load_ok   = (load_addr[1:0] == 2'b00) && (load_addr <= LAST_WORD);
  assign w_fetch_bad = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_WORD);

  always_comb begin
    w_next    = r_state;
    w_gnt     = 1'b0;
    w_idx     = 2'd0;
    mem_addr  = fetch_pc;
    mem_we    = 1'b0;
    mem_wbyte = '0;
    case (r_state)
      IDLE: begin
        if (w_load_wins) begin
          if (w_load_ok) w_next = WB0;
        end else if (fetch_req) begin
          w_gnt = 1'b1;
        end
      end
      WB0: begin w_idx = 2'd0; w_next = WB1;  end
      WB1: begin w_idx = 2'd1; w_next = WB2;  end
      WB2: begin w_idx = 2'd2; w_next = WB3;  end
      WB3: begin w_idx = 2'd3; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
    if (!w_idle) begin
      mem_we   = 1'b1;
      mem_addr = r_lat_addr + {30'd0, w_idx};
      case (w_idx)
        2'd0:    mem_wbyte = r_lat_data[31:24];
        2'd1:    mem_wbyte = r_lat_data[23:16];
        2'd2:    mem_wbyte = r_lat_data[15:8];
        default: mem_wbyte = r_lat_data[7:0];
      endcase
    end
    // Combinational outputs are forced low while reset is held.
    if (!rst_n) begin
      w_gnt     = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wbyte = '0;
    end
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (!load_req)
      w_starve_nxt = '0;
    else if (w_idle && w_load_wins)
      w_starve_nxt = '0;
    else if (w_gnt && r_starve != SLIM)
      w_starve_nxt = r_starve + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_starve      <= '0;
      r_lat_addr    <= '0;
      r_lat_data    <= '0;
      r_fetch_valid <= 1'b0;
      r_fetch_fault <= 1'b0;
      r_fetch_instr <= '0;
      r_load_err    <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_starve      <= w_starve_nxt;
      r_load_err    <= w_idle && w_load_wins && !w_load_ok;
      r_fetch_valid <= w_gnt;
      r_fetch_fault <= w_gnt && w_fetch_bad;
      if (w_idle && w_load_wins && w_load_ok) begin
        r_lat_addr <= load_addr;
        r_lat_data <= load_data;
      end
      if (w_gnt)
        r_fetch_instr <= w_fetch_bad ? '0 : mem_rdata;
    end
  end

  assign fetch_gnt   = w_gnt;
  assign fetch_valid = r_fetch_valid;
  assign fetch_fault = r_fetch_fault;
  assign fetch_instr = r_fetch_instr;
  assign load_err    = r_load_err;
  assign load_ack    = (r_state == WB3) && rst_n;

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Scoreboard bench for imem_access_arbiter: directed stimulus pushes expected
// fetch responses, memory byte writes and load events; a negedge monitor checks them.
`timescale 1ns/1ps
module tb_imem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, fetch_gnt, fetch_valid, fetch_fault;
  logic [31:0] fetch_pc, fetch_instr;
  logic        load_req, load_ack, load_err;
  logic [31:0] load_addr, load_data;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_we;
  logic [7:0]  mem_wbyte;

  logic [7:0]  mem [16384];
  logic [31:0] a1, a2, a3;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] fq[$];   // {fault, instr}
  logic [39:0] wq[$];   // {addr, byte}
  int          evq[$];  // 1 = ack, 2 = err

  always #5 clk = ~clk;

  imem_access_arbiter #(.MEM_BYTES(16384), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_gnt(fetch_gnt),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_fault(fetch_fault),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data),
    .load_ack(load_ack), .load_err(load_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wbyte(mem_wbyte), .mem_rdata(mem_rdata)
  );

  assign a1 = mem_addr + 32'd1;
  assign a2 = mem_addr + 32'd2;
  assign a3 = mem_addr + 32'd3;
  assign mem_rdata = {(mem_addr < 32'd16384) ? mem[mem_addr[13:0]] : 8'h00,
                      (a1 < 32'd16384) ? mem[a1[13:0]] : 8'h00,
                      (a2 < 32'd16384) ? mem[a2[13:0]] : 8'h00,
                      (a3 < 32'd16384) ? mem[a3[13:0]] : 8'h00};

  always @(posedge clk)
    if (mem_we && mem_addr < 32'd16384) mem[mem_addr[13:0]] <= mem_wbyte;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every DUT output event is matched against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (fetch_valid) begin
        if (fq.size() == 0) chk("unexpected_fetch_valid", 64'd1, 64'd0);
        else chk("fetch_resp", {31'd0, fetch_fault, fetch_instr}, {31'd0, fq.pop_front()});
      end
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_mem_we", {24'd0, mem_addr, mem_wbyte}, 64'd0);
        else chk("mem_write", {24'd0, mem_addr, mem_wbyte}, {24'd0, wq.pop_front()});
      end
      if (load_ack || load_err) begin
        if (evq.size() == 0) chk("unexpected_load_event", {62'd0, load_err, load_ack}, 64'd0);
        else chk("load_event", 64'(load_ack ? 1 : 2), 64'(evq.pop_front()));
      end
    end
  end

  task automatic push_writes(input logic [31:0] addr, input logic [31:0] data, input int n);
    for (int k = 0; k < n; k++)
      wq.push_back({addr + 32'(k), data[31-8*k -: 8]});
  endtask

  task automatic do_fetch(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
    @(posedge clk); #1;
    fetch_req = 1'b1;
    fetch_pc  = pc;
    fq.push_back({fault, instr});
    @(negedge clk);
    chk("fetch_gnt", {63'd0, fetch_gnt}, 64'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input logic ok);
    logic seen;
    seen = 1'b0;
    @(posedge clk); #1;
    load_req  = 1'b1;
    load_addr = addr;
    load_data = data;
    if (ok) begin
      push_writes(addr, data, 4);
      evq.push_back(1);
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (load_ack) seen = 1'b1;
      end
      chk("load_ack_seen", {63'd0, seen}, 64'd1);
      @(posedge clk); #1;
      load_req = 1'b0;
    end else begin
      evq.push_back(2);
      @(posedge clk); #1;
      load_req = 1'b0;
      @(negedge clk);
      chk("load_err_pulse", {63'd0, load_err}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_pat[10];
    gnt_pat = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[100] = 8'h48; mem[101] = 8'h08; mem[102] = 8'h00; mem[103] = 8'h00;

    // Reset with every input active.
    rst_n = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'd100;
    load_req = 1'b1; load_addr = 32'd200; load_data = 32'hFFFF_FFFF;
    #12;
    chk("rst_fetch_gnt",   {63'd0, fetch_gnt},   64'd0);
    chk("rst_fetch_valid", {63'd0, fetch_valid}, 64'd0);
    chk("rst_fetch_fault", {63'd0, fetch_fault}, 64'd0);
    chk("rst_fetch_instr", {32'd0, fetch_instr}, 64'd0);
    chk("rst_load_evts",   {62'd0, load_ack, load_err}, 64'd0);
    chk("rst_mem_bus",     {23'd0, mem_we, mem_wbyte, mem_addr}, 64'd0);
    fetch_req = 1'b0; load_req = 1'b0; fetch_pc = '0; load_addr = '0; load_data = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_mem_we", {63'd0, mem_we},    64'd0);
    chk("idle_gnt",    {63'd0, fetch_gnt}, 64'd0);

    do_fetch(32'd100, 32'h4808_0000, 1'b0);
    do_load(32'd200, 32'h2413_0005, 1'b1);
    do_fetch(32'd200, 32'h2413_0005, 1'b0);

    // Starvation: fetch held high, loader forced through after 4 fetch wins.
    for (int k = 0; k < 5; k++) fq.push_back({1'b0, 32'h4808_0000});
    push_writes(32'd300, 32'hDEAD_BEEF, 4);
    evq.push_back(1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        fetch_req = 1'b1; fetch_pc = 32'd100;
        load_req = 1'b1; load_addr = 32'd300; load_data = 32'hDEAD_BEEF;
      end
      if (i == 9) load_req = 1'b0;
      @(negedge clk);
      chk($sformatf("starve_gnt[%0d]", i), {63'd0, fetch_gnt}, 64'(gnt_pat[i]));
    end
    @(posedge clk); #1;
    fetch_req = 1'b0;
    do_fetch(32'd300, 32'hDEAD_BEEF, 1'b0);

    // Boundaries.
    do_load(32'd202,   32'h1234_5678, 1'b0);
    do_load(32'd16384, 32'h1234_5678, 1'b0);
    do_fetch(32'd16380, 32'hA6A7_A4A5, 1'b0);
    do_load(32'd16380, 32'h1122_3344, 1'b1);
    do_fetch(32'd16380, 32'h1122_3344, 1'b0);
    do_fetch(32'd16382, 32'h0, 1'b1);
    do_fetch(32'd101,   32'h0, 1'b1);

    // Reset during WB2 aborts the burst after two bytes.
    push_writes(32'd400, 32'hAABB_CCDD, 2);
    @(posedge clk); #1;
    load_req = 1'b1; load_addr = 32'd400; load_data = 32'hAABB_CCDD;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    load_req = 1'b0;
    #1;
    chk("abort_mem_we",   {63'd0, mem_we},   64'd0);
    chk("abort_load_ack", {63'd0, load_ack}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_we", {63'd0, mem_we}, 64'd0);
    chk("abort_mem400", {32'd0, mem[400], mem[401], mem[402], mem[403]}, 64'h0000_0000_AABB_C8C9);
    do_fetch(32'd400, 32'hAABB_C8C9, 1'b0);

    repeat (3) @(negedge clk);
    chk("fetch_q_drained", 64'(fq.size()),  64'd0);
    chk("write_q_drained", 64'(wq.size()),  64'd0);
    chk("event_q_drained", 64'(evq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Shares the byte-organised instruction memory between the pipeline fetch stage and a program loader.
- Fetch requests get one 32-bit big-endian read per cycle.
- Loader requests are serialised into 4-cycle byte-write bursts into the memory's single byte-wide write port.
- Fetch has priority; a starvation counter guarantees the loader eventually wins.

Parameters:
- MEM_BYTES, 16384, instruction memory size in bytes.
- STARVE_LIMIT, 4, number of fetch-won contention cycles after which a pending load is forced through.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- fetch_req  in  1  fetch stage requests an instruction
- fetch_pc  in  32  byte address of instruction
- fetch_gnt  out  1  fetch accepted this cycle (combinational)
- fetch_valid  out  1  fetch_instr/fetch_fault valid (registered, 1 cycle after gnt)
- fetch_instr  out  32  fetched instruction
- fetch_fault  out  1  fetch address misaligned or out of range
- load_req  in  1  loader requests a word write
- load_addr  in  32  word byte address
- load_data  in  32  word to write; [31:24] goes to load_addr+0
- load_ack  out  1  one-cycle pulse, burst completing
- load_err  out  1  one-cycle pulse, load rejected
- mem_addr  out  32  memory byte address
- mem_we  out  1  byte write enable
- mem_wbyte  out  8  byte to write
- mem_rdata  in  32  {mem[a],mem[a+1],mem[a+2],mem[a+3]} for a = mem_addr, combinational

Behaviour:
- Reset (async, rst_n=0): state=IDLE, starve_cnt=0; all outputs 0, including fetch_instr. A reset mid-burst aborts the burst: bytes already written stay written, no load_ack is issued.
- States:
  - IDLE.
  - WB0, WB1, WB2, WB3: burst states; byte index = state - WB0.
- Loader-wins condition in IDLE: load_req && (!fetch_req || starve_cnt==STARVE_LIMIT).
- IDLE, loader wins:
  - load_addr[1:0]==0 and load_addr<=MEM_BYTES-4: latch addr/data, go to WB0, clear starve_cnt.
  - Otherwise: load_err=1 next cycle, stay IDLE, clear starve_cnt, no write.
- IDLE, fetch_req and loader does not win:
  - fetch_gnt=1, mem_addr=fetch_pc.
  - Next cycle fetch_valid=1, fetch_instr=mem_rdata sampled at the grant edge.
  - If fetch_pc[1:0]!=0 or fetch_pc>MEM_BYTES-4: fetch_fault=1 and fetch_instr=0 instead.
- IDLE otherwise: mem_addr=fetch_pc, mem_we=0.
- fetch_valid and fetch_fault are 0 in any cycle not preceded by a grant. fetch_instr holds its last value.
- Starve counter: increments (saturating at STARVE_LIMIT) each IDLE cycle with load_req && fetch_gnt; clears whenever load_req=0.
- WBn burst state:
  - mem_we=1, mem_addr=lat_addr+n, mem_wbyte=lat_data[31-8n -: 8].
  - fetch_gnt=0 regardless of fetch_req.
  - WBn advances to WB(n+1); WB3 returns to IDLE.
- load_ack=1 combinationally during WB3. Loader must drop load_req in the cycle after ack; a load_req still high in IDLE starts a new burst.
- Burst length is fixed at 4 cycles (request edge to IDLE = 5 cycles). The loader is blocked for at most STARVE_LIMIT+1 cycles under continuous fetch.
- A fetch of an address being written in the same burst returns old/partial bytes. Software orders loads before fetch; the arbiter does not check this.

Test Plan:
- Reset with all inputs active → all outputs 0; after release with fetch_req=0 and load_req=0, the block idles with mem_we=0.
- Memory preloaded with word 0x48080000 at byte 100; fetch_req=1, pc=100 → fetch_gnt=1 in the same cycle; next cycle fetch_valid=1, fetch_instr=0x48080000, fetch_fault=0.
- load_req with addr=200, data=0x24130005, no fetch → mem_we for 4 cycles at addr 200..203 with bytes 24,13,00,05; load_ack in 4th cycle; then fetch pc=200 returns 0x24130005.
- fetch_req held high, load_req raised with addr=300 → fetch granted 4 cycles (starve_cnt 1..4); 5th cycle loader wins; fetch_gnt=0 for 4 cycles; fetch_gnt=1 the cycle after WB3.
- load_addr=202 (misaligned) or 16384 → load_err pulse, no mem_we. Fetch pc=16382 or pc=101 → fetch_valid=1, fetch_fault=1, fetch_instr=0.
- rst_n asserted during WB2 of write 0xAABBCCDD to addr 400 → mem[400]=AA, mem[401]=BB, 402/403 unchanged, no load_ack, state IDLE after release.
